// File: rtl/seq_magnitude_compare_ctrl_pkg.sv
// Shared types for the slice-serial magnitude comparator: FSM states,
// slice width and the lt/gt/eq result bundle.
package seq_cmp_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} seq_cmp_state_t;

  typedef struct packed {
    logic lt;
    logic gt;
    logic eq;
  } cmp_result_t;

  localparam cmp_result_t RES_NONE = '{lt: 1'b0, gt: 1'b0, eq: 1'b0};
  localparam cmp_result_t RES_EQ   = '{lt: 1'b0, gt: 1'b0, eq: 1'b1};

endpackage

// File: rtl/seq_magnitude_compare_ctrl_if.sv
// Operand request / result response bundle of the sequential comparator.
// The master drives operands and out_ready; the slave answers with flags.
interface seq_magnitude_compare_ctrl_if #(
  parameter int N = 32
);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic         lt;
  logic         gt;
  logic         eq;
  logic         busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, lt, gt, eq, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, lt, gt, eq, busy
  );

endinterface

// File: rtl/seq_magnitude_compare_ctrl_nibble.sv
// Combinational 4-bit unsigned compare slice; the sequencer reuses one
// instance for every slice of the wide operands.
module nibble_compare4
  import seq_cmp_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  output cmp_result_t         res_o
);

  always_comb begin
    res_o.lt = (a_i <  b_i);
    res_o.gt = (a_i >  b_i);
    res_o.eq = (a_i == b_i);
  end

endmodule

// File: rtl/seq_magnitude_compare_ctrl.sv
// Sequential wide magnitude comparator: walks captured operands one nibble
// per clock from the MSB slice down and stops at the first unequal slice.
module seq_magnitude_compare_ctrl
  import seq_cmp_pkg::*;
#(
  parameter int N      = 32,
  parameter bit SIGNED = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  seq_magnitude_compare_ctrl_if.slave  bus
);

  localparam int SLICES = N / NIBBLE_W;
  localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(SLICES - 1);

  seq_cmp_state_t   state_q, state_d;
  logic [N-1:0]     a_q, b_q;
  logic [IDX_W-1:0] idx_q;
  cmp_result_t      res_q;
  cmp_result_t      slice_res;
  logic [NIBBLE_W-1:0] a_sl, b_sl;
  logic             accept;
  logic             last_slice;

  // Flipping the sign bit of both operands maps two's-complement order onto
  // unsigned order, so the same unsigned slice serves both modes.
  function automatic logic [N-1:0] bias_sign(input logic [N-1:0] v);
    logic [N-1:0] r;
    r = v;
    if (SIGNED) r[N-1] = ~v[N-1];
    return r;
  endfunction

  assign accept     = bus.in_valid && (state_q == IDLE);
  assign last_slice = (idx_q == '0);

  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < SLICES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_sl = a_q[i*NIBBLE_W +: NIBBLE_W];
        b_sl = b_q[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  nibble_compare4 u_slice (
    .a_i   (a_sl),
    .b_i   (b_sl),
    .res_o (slice_res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = SCAN;
      SCAN: if (!slice_res.eq || last_slice) state_d = DONE;
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.busy      = (state_q == SCAN) || (state_q == DONE);
    bus.out_valid = (state_q == DONE);
    bus.lt        = res_q.lt;
    bus.gt        = res_q.gt;
    bus.eq        = res_q.eq;
  end

  // Operand copies are pure data; they are only read after an accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= bias_sign(bus.a);
      b_q <= bias_sign(bus.b);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      res_q <= RES_NONE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            idx_q <= IDX_TOP;
            res_q <= RES_NONE;
          end
        end
        SCAN: begin
          if (!slice_res.eq)   res_q <= slice_res;
          else if (last_slice) res_q <= RES_EQ;
          else                 idx_q <= idx_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_magnitude_compare_ctrl.sv
// Bench for the sequential comparator: an unsigned and a signed instance run
// in lockstep on shared stimulus and are checked against arithmetic models.
module tb_seq_magnitude_compare_ctrl;

  localparam int N = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b0;
  logic [N-1:0] a_drv     = '0;
  logic [N-1:0] b_drv     = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_magnitude_compare_ctrl_if #(.N(N)) if_u ();
  seq_magnitude_compare_ctrl_if #(.N(N)) if_s ();

  assign if_u.in_valid  = in_valid;
  assign if_u.out_ready = out_ready;
  assign if_u.a         = a_drv;
  assign if_u.b         = b_drv;
  assign if_s.in_valid  = in_valid;
  assign if_s.out_ready = out_ready;
  assign if_s.a         = a_drv;
  assign if_s.b         = b_drv;

  seq_magnitude_compare_ctrl #(.N(N), .SIGNED(1'b0)) dut_u (
    .clk (clk),
    .rst (rst),
    .bus (if_u)
  );

  seq_magnitude_compare_ctrl #(.N(N), .SIGNED(1'b1)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (if_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {lt,gt,eq} from plain integer comparison.
  function automatic logic [2:0] ref_flags(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input bit sgn);
    if (sgn) begin
      if ($signed(a) < $signed(b)) return 3'b100;
      if ($signed(a) > $signed(b)) return 3'b010;
    end else begin
      if (a < b) return 3'b100;
      if (a > b) return 3'b010;
    end
    return 3'b001;
  endfunction

  // Reference latency: slices visited until the first differing nibble from the top.
  function automatic int ref_lat(input logic [N-1:0] a, input logic [N-1:0] b);
    for (int i = N/4 - 1; i >= 0; i--)
      if (((a >> (4*i)) & 16'hF) != ((b >> (4*i)) & 16'hF)) return N/4 - i;
    return N/4;
  endfunction

  task automatic check_flags(input string tag, input logic [N-1:0] a, input logic [N-1:0] b);
    check({tag, "_u"}, {29'd0, if_u.lt, if_u.gt, if_u.eq}, {29'd0, ref_flags(a, b, 1'b0)});
    check({tag, "_s"}, {29'd0, if_s.lt, if_s.gt, if_s.eq}, {29'd0, ref_flags(a, b, 1'b1)});
    check({tag, "_1hot"}, 32'(if_u.lt + if_u.gt + if_u.eq + if_s.lt + if_s.gt + if_s.eq), 32'd2);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_vld"},  {30'd0, if_u.out_valid, if_s.out_valid}, 32'd0);
    check({tag, "_rdy"},  {30'd0, if_u.in_ready,  if_s.in_ready},  32'd3);
    check({tag, "_busy"}, {30'd0, if_u.busy,      if_s.busy},      32'd0);
  endtask

  // Waits (bounded) for out_valid after the accept edge; returns clocks taken, 0 on timeout.
  task automatic wait_result(output int k);
    k = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (if_u.out_valid || if_s.out_valid) begin
        k = c;
        break;
      end
    end
  endtask

  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input int stall,
                       input string tag);
    int k;
    @(negedge clk);
    a_drv = a; b_drv = b; in_valid = 1'b1; out_ready = 1'b0;
    check({tag, "_inrdy"}, {30'd0, if_u.in_ready, if_s.in_ready}, 32'd3);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result(k);
    check({tag, "_lat"}, 32'(k), 32'(ref_lat(a, b)));
    check({tag, "_vld"}, {30'd0, if_u.out_valid, if_s.out_valid}, 32'd3);
    check_flags(tag, a, b);
    for (int s = 0; s < stall; s++) begin
      a_drv = N'($urandom); b_drv = N'($urandom);
      @(posedge clk); #1;
      check({tag, "_stall_vld"}, {30'd0, if_u.out_valid, if_s.out_valid}, 32'd3);
      check({tag, "_stall_rdy"}, {30'd0, if_u.in_ready, if_s.in_ready}, 32'd0);
      check_flags({tag, "_stall"}, a, b);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_idle({tag, "_done"});
  endtask

  task automatic abort_op();
    @(negedge clk);
    a_drv = 16'h0001; b_drv = 16'h0002; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", {30'd0, if_u.busy, if_s.busy}, 32'd3);
    rst = 1'b1;
    #1;
    check_idle("abort");
    check("abort_flags", {26'd0, if_u.lt, if_u.gt, if_u.eq, if_s.lt, if_s.gt, if_s.eq}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [N-1:0] rand_b(input logic [N-1:0] a);
    unique case ($urandom_range(3, 0))
      0:       return N'($urandom);
      1:       return a;
      2:       return a ^ (N'(1) << $urandom_range(N-1, 0));
      default: return {~a[N-1], a[N-2:0]};
    endcase
  endfunction

  task automatic back_to_back(input int ops);
    int k;
    logic [N-1:0] a, b;
    a = N'($urandom); b = rand_b(a);
    @(negedge clk);
    a_drv = a; b_drv = b; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < ops; i++) begin
      check("b2b_inrdy", {30'd0, if_u.in_ready, if_s.in_ready}, 32'd3);
      @(posedge clk); #1;
      wait_result(k);
      check("b2b_lat", 32'(k), 32'(ref_lat(a, b)));
      check_flags("b2b", a, b);
      @(posedge clk); #1;
      check_idle("b2b_gap");
      a = N'($urandom); b = rand_b(a);
      a_drv = a; b_drv = b;
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    check("reset_flags", {26'd0, if_u.lt, if_u.gt, if_u.eq, if_s.lt, if_s.gt, if_s.eq}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op(16'h1234, 16'h1235, 0, "lt_low");
    do_op(16'h8000, 16'h7FFF, 0, "signbit");
    do_op(16'hABCD, 16'hABCD, 0, "eq_abcd");
    do_op(16'h0000, 16'h0000, 0, "eq_zero");
    do_op(16'hFFFF, 16'hFFFF, 0, "eq_ones");
    do_op(16'h0F00, 16'h0E00, 5, "stall");
    abort_op();
    do_op(16'h0002, 16'h0001, 0, "post_abort");
    back_to_back(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
